// File: rtl/pmem_loader.sv
// Program-memory loader: turns a length-prefixed byte stream into 16-bit writes and holds the CPU in reset until a clean load ends.
// Optional trailing checksum byte is enabled by defining PMEM_LOADER_CHECKSUM_EN.
module pmem_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] count,
  output logic [2:0]  dbg_state
);

  // Byte stream handshake: a byte transfers on a rising clock edge where in_valid and in_ready are both 1;
  // in_ready depends only on the state, never on in_valid.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
`ifdef PMEM_LOADER_CHECKSUM_EN
    CSUM    = 3'd5,
`endif
    DONE    = 3'd6
  } state_t;

`ifdef PMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t      state, state_nxt;
  logic [10:0] len_q;
  logic [7:0]  lo_byte;
  logic        accept;
  logic [15:0] len_word;
  logic [10:0] len_clamped;
  logic [10:0] count_inc;

  assign accept      = in_valid & in_ready;
  assign len_word    = {in_data, len_q[7:0]};
  assign len_clamped = (len_word > 16'd1024) ? 11'd1024 : len_word[10:0];
  assign count_inc   = count + 11'd1;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign dbg_state   = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = LEN_LO;
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (len_word != 16'd0) ? DATA_LO : POST_DATA;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DATA_HI;
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (count_inc < len_q) ? DATA_LO : POST_DATA;
      end
`ifdef PMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DONE;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum <= 8'd0;
    end else if (state == IDLE && start) begin
      sum <= 8'd0;
    end else if (accept && (state == DATA_LO || state == DATA_HI)) begin
      sum <= sum + in_data;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q     <= 11'd0;
      lo_byte   <= 8'd0;
      count     <= 11'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 16'd0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      if (state == IDLE && start) begin
        count    <= 11'd0;
        err      <= 1'b0;
        cpu_hold <= 1'b1;
      end
      if (accept) begin
        case (state)
          LEN_LO:  len_q   <= {3'd0, in_data};
          LEN_HI:  len_q   <= len_clamped;
          DATA_LO: lo_byte <= in_data;
          DATA_HI: begin
            // count is at most 1023 here, so the address stays inside 0..2046
            mem_we    <= 1'b1;
            mem_wdata <= {in_data, lo_byte};
            mem_addr  <= {20'd0, count, 1'b0};
            count     <= count_inc;
          end
`ifdef PMEM_LOADER_CHECKSUM_EN
          CSUM:    err <= (in_data != sum);
`endif
          default: ;
        endcase
      end
      // Release the CPU only when the session that just ended was clean
      if (state == DONE) cpu_hold <= err;
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: drives length-prefixed byte streams and scores every memory write
// against an expected queue; covers reset, zero length, stalls, mid-session reset and length clamping.
module tb_pmem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [10:0] count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int n_writes = 0;
  logic [31:0] last_addr = 32'd0;
  logic [47:0] exp_q[$];
  logic [7:0]  fix_q[$];

  pmem_loader dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .count(count),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard consumer
  always @(negedge clock) begin
    logic [47:0] e;
    if (reset && mem_we) begin
      n_writes++;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_addr", mem_addr, e[47:16]);
        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e[15:0]});
        last_addr = mem_addr;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int stall);
    int n;
    repeat (stall) @(negedge clock);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("count_after_start", {21'd0, count}, 32'd0);
  endtask

  // csum < 0 sends the correct checksum; start_at >= 0 raises start during that halfword
  task automatic run_session(input int n16, input int stall, input int csum, input int start_at);
    int n_eff, n, writes0;
    logic [7:0] lo, hi, sum, cs;
    logic exp_err;
    logic [15:0] len;
    len = 16'(n16);
    n_eff = (n16 > 1024) ? 1024 : n16;
    sum = 8'd0;
    exp_err = 1'b0;
    writes0 = n_writes;
    pulse_start();
    send_byte(len[7:0], 0);
    send_byte(len[15:8], stall);
    for (int i = 0; i < n_eff; i++) begin
      lo = (fix_q.size() > 0) ? fix_q.pop_front() : 8'($urandom_range(0, 255));
      hi = (fix_q.size() > 0) ? fix_q.pop_front() : 8'($urandom_range(0, 255));
      if (i == start_at) start = 1'b1;
      send_byte(lo, stall);
      start = 1'b0;
      exp_q.push_back({32'(2 * i), hi, lo});
      send_byte(hi, stall);
      sum = sum + lo + hi;
    end
`ifdef PMEM_LOADER_CHECKSUM_EN
    cs = (csum < 0) ? sum : 8'(csum);
    exp_err = (cs != sum);
    send_byte(cs, stall);
`else
    cs = 8'(csum);
`endif
    @(negedge clock);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("count_final", {21'd0, count}, 32'(n_eff));
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("cpu_hold_end", {31'd0, cpu_hold}, {31'd0, exp_err});
    check("count_held", {21'd0, count}, 32'(n_eff));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(n_writes - writes0), 32'(n_eff));
    if (n_eff > 0) check("last_addr", last_addr, 32'(2 * (n_eff - 1)));
  endtask

  initial begin
    // Reset state, held before any session
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_count", {21'd0, count}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Basic two-halfword load, start on the first edge after reset release
    fix_q = '{8'h01, 8'h11, 8'h02, 8'h22};
    run_session(2, 0, -1, -1);

    // Zero length
    run_session(0, 0, -1, -1);

    // Stream stalls every other cycle
    run_session(3, 1, -1, -1);

    // Reset in the middle of a four-halfword session
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({32'd0, 8'hbb, 8'haa});
    send_byte(8'haa, 0);
    send_byte(8'hbb, 0);
    send_byte(8'hcc, 0);
    @(negedge clock);
    check("mid_count", {21'd0, count}, 32'd1);
    check("mid_queue", 32'(exp_q.size()), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_mem_we", {31'd0, mem_we}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("arst_count", {21'd0, count}, 32'd0);
    check("arst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    run_session(1, 0, -1, -1);

`ifdef PMEM_LOADER_CHECKSUM_EN
    // Good then bad checksum; the bad one must keep the CPU held
    fix_q = '{8'h34, 8'h12};
    run_session(1, 0, -1, -1);
    fix_q = '{8'h34, 8'h12};
    run_session(1, 0, 8'h44, -1);
`endif

    // Oversized length clamps to 1024 halfwords; start mid-session is ignored
    run_session(16'h0500, 0, -1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
